// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: counter widths and window slot ordering shared by the
// window generator, the calc stage and the bench.
package conv_window_gen_pkg;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int slot_idx(input int a, input int b, input int k);
    return a * k + b;
  endfunction
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// conv_line_buffer: single-row delay line, shifts one pixel per enable.
module conv_line_buffer #(
  parameter int DEPTH = 25,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);
  logic [N-1:0] sr_q [DEPTH];
  logic [N-1:0] sr_d [DEPTH];
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
  end
  always_ff @(posedge clk) sr_q <= sr_d;
  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into packed KERNEL x KERNEL
// windows for the convolution calc stage (valid positions only).
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N = 4,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N-1:0]               pix_in,
  input  logic                       pix_valid,
  output logic [KERNEL*KERNEL*N-1:0] data2conv,
  output logic                       en_out,
  output logic                       frame_done
);
  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int LB_D = IMG_W - KERNEL;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic en_q, en_d, fd_q, fd_d;
  logic acc, last_col, last_row;
  logic [N-1:0] win_q [KERNEL][KERNEL];
  logic [N-1:0] win_d [KERNEL][KERNEL];
  logic [N-1:0] col_in [KERNEL];
  assign acc = pix_valid & ~flush;
  assign col_in[KERNEL-1] = pix_in;
  // Pixels leaving the left edge of window row a+1 re-enter row a one image row later.
  for (genvar a = 0; a < KERNEL - 1; a++) begin : g_lb
    if (LB_D > 0) begin : g_buf
      conv_line_buffer #(.DEPTH(LB_D), .N(N)) u_lb (
        .clk(clk),
        .en(acc),
        .din(win_q[a+1][0]),
        .dout(col_in[a])
      );
    end else begin : g_wire
      assign col_in[a] = win_q[a+1][0];
    end
  end
  for (genvar a = 0; a < KERNEL; a++) begin : g_row
    for (genvar b = 0; b < KERNEL; b++) begin : g_col
      assign data2conv[slot_idx(a, b, KERNEL)*N +: N] = win_q[a][b];
    end
  end
  always_comb begin
    last_col = col_q == COL_W'(IMG_W - 1);
    last_row = row_q == ROW_W'(IMG_H - 1);
    col_d = flush ? '0 : !acc ? col_q : last_col ? '0 : col_q + COL_W'(1);
    row_d = flush ? '0 : !(acc && last_col) ? row_q : last_row ? '0 : row_q + ROW_W'(1);
    en_d = acc && (int'(row_q) >= KERNEL - 1) && (int'(col_q) >= KERNEL - 1);
    fd_d = acc && last_col && last_row;
    win_d = win_q;
    if (acc) begin
      for (int a = 0; a < KERNEL; a++) begin
        for (int b = 0; b < KERNEL - 1; b++) win_d[a][b] = win_q[a][b+1];
        win_d[a][KERNEL-1] = col_in[a];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      en_q <= 1'b0;
      fd_q <= 1'b0;
      for (int a = 0; a < KERNEL; a++)
        for (int b = 0; b < KERNEL; b++) win_q[a][b] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      en_q <= en_d;
      fd_q <= fd_d;
      win_q <= win_d;
    end
  end
  assign en_out = en_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random and directed streams checked against an image-array model.
module tb_conv_window_gen;
  localparam int K = 3;
  localparam int N = 4;
  localparam int W = 5;
  localparam int H = 4;
  localparam int WB = K * K * N;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic pix_valid = 1'b0;
  logic v1 = 1'b0;
  logic [N-1:0] pix_in = '0;
  logic [N-1:0] p1 = '0;
  logic [WB-1:0] data2conv;
  logic en_out, frame_done;
  logic [N-1:0] d1;
  logic en1, fd1;
  int checks = 0;
  int errors = 0;
  int mr = 0;
  int mc = 0;
  int n_en = 0;
  int n_fd = 0;
  int k1n = 0;
  logic [N-1:0] img [H][W];
  logic exp_en = 1'b0;
  logic exp_fd = 1'b0;
  logic exp1_fd = 1'b0;
  logic got_first = 1'b0;
  logic [WB-1:0] exp_win = '0;
  logic [WB-1:0] first_win = '0;
  logic [WB-1:0] last_win = '0;
  always #5 clk = ~clk;
  conv_window_gen #(.KERNEL(K), .N(N), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pix_in(pix_in), .pix_valid(pix_valid),
    .data2conv(data2conv), .en_out(en_out), .frame_done(frame_done)
  );
  conv_window_gen #(.KERNEL(1), .N(N), .IMG_W(2), .IMG_H(2)) dut_k1 (
    .clk(clk), .rst(rst), .flush(flush), .pix_in(p1), .pix_valid(v1),
    .data2conv(d1), .en_out(en1), .frame_done(fd1)
  );
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endfunction
  function automatic logic [N-1:0] pat(input int r, input int c);
    return N'((r * W + c) % 16);
  endfunction
  task automatic cyc(input logic v, input logic f, input logic [N-1:0] p);
    pix_valid = v;
    flush = f;
    pix_in = p;
    @(posedge clk);
    exp_en = 1'b0;
    exp_fd = 1'b0;
    if (rst && f) begin
      mr = 0;
      mc = 0;
    end else if (rst && v) begin
      img[mr][mc] = p;
      if (mr >= K - 1 && mc >= K - 1) begin
        exp_en = 1'b1;
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++) exp_win[(a*K+b)*N +: N] = img[mr-K+1+a][mc-K+1+b];
      end
      exp_fd = (mr == H - 1) && (mc == W - 1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    #1;
    chk("en_out", 64'(en_out), 64'(exp_en));
    chk("frame_done", 64'(frame_done), 64'(exp_fd));
    if (exp_en) chk("window", 64'(data2conv), 64'(exp_win));
    if (en_out) begin
      n_en++;
      last_win = data2conv;
      if (!got_first) begin
        first_win = data2conv;
        got_first = 1'b1;
      end
    end
    if (frame_done) n_fd++;
  endtask
  task automatic cyc1(input logic v, input logic [N-1:0] p);
    v1 = v;
    p1 = p;
    @(posedge clk);
    exp1_fd = v && (k1n % 4 == 3);
    if (v) k1n++;
    #1;
    chk("k1_en", 64'(en1), 64'(v));
    chk("k1_fd", 64'(fd1), 64'(exp1_fd));
    if (v) chk("k1_data", 64'(d1), 64'(p));
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    mr = 0;
    mc = 0;
    exp_en = 1'b0;
    exp_fd = 1'b0;
    #1;
    chk("rst_en", 64'(en_out), 64'(0));
    chk("rst_fd", 64'(frame_done), 64'(0));
    chk("rst_data", 64'(data2conv), 64'(0));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    rst = 1'b1;
  endtask
  task automatic clear_counts();
    n_en = 0;
    n_fd = 0;
    got_first = 1'b0;
  endtask
  task automatic frame(input bit rnd_pix, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, N'($urandom));
        cyc(1'b1, 1'b0, rnd_pix ? N'($urandom) : pat(r, c));
      end
  endtask
  initial begin
    reset_dut();
    clear_counts();
    frame(1'b0, 1'b0);
    chk("first_win", 64'(first_win), 64'(36'hCBA765210));
    chk("last_win", 64'(last_win), 64'(36'h321EDC987));
    chk("n_en", 64'(n_en), 64'(6));
    chk("n_fd", 64'(n_fd), 64'(1));
    clear_counts();
    frame(1'b0, 1'b1);
    chk("gap_first_win", 64'(first_win), 64'(36'hCBA765210));
    chk("gap_last_win", 64'(last_win), 64'(36'h321EDC987));
    chk("gap_n_en", 64'(n_en), 64'(6));
    chk("gap_n_fd", 64'(n_fd), 64'(1));
    for (int i = 0; i < 3; i++) begin
      clear_counts();
      frame(1'b1, 1'b1);
      chk("rnd_n_en", 64'(n_en), 64'(6));
      chk("rnd_n_fd", 64'(n_fd), 64'(1));
    end
    for (int i = 0; i <= 8; i++) cyc(1'b1, 1'b0, pat(i / W, i % W));
    reset_dut();
    clear_counts();
    frame(1'b0, 1'b0);
    chk("rst_first_win", 64'(first_win), 64'(36'hCBA765210));
    chk("rst_n_en", 64'(n_en), 64'(6));
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, pat(i / W, i % W));
    cyc(1'b1, 1'b1, pat(1, 2));
    clear_counts();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    chk("b2b_n_en", 64'(n_en), 64'(12));
    chk("b2b_n_fd", 64'(n_fd), 64'(2));
    chk("b2b_last_win", 64'(last_win), 64'(36'h321EDC987));
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, N'($urandom));
    cyc(1'b0, 1'b1, '0);
    clear_counts();
    frame(1'b1, 1'b1);
    chk("flush_n_en", 64'(n_en), 64'(6));
    cyc1(1'b1, 4'b0011);
    chk("k1_lit0", 64'(d1), 64'(4'b0011));
    cyc1(1'b1, 4'b1110);
    chk("k1_lit1", 64'(d1), 64'(4'b1110));
    cyc1(1'b1, 4'b0111);
    chk("k1_lit2", 64'(d1), 64'(4'b0111));
    for (int i = 0; i < 30; i++) cyc1(1'($urandom_range(0, 1)), N'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the convolution calculation stage: converts a raster-order pixel stream into one KERNEL x KERNEL window per valid output position.
- Packs each window into the flat `data2conv` bus and strobes `en_out`, which connects directly to the calc stage's `en_in`.
- "Valid" convolution only (no padding); output grid is (IMG_W-KERNEL+1) x (IMG_H-KERNEL+1).
- Built from KERNEL-1 row line buffers plus a KERNEL x KERNEL register window.

Parameters:
- KERNEL, 3, window side (1/3/5/7).
- N, 4, pixel width in bits.
- IMG_W, 28, image width in pixels (>= KERNEL).
- IMG_H, 28, image height in pixels (>= KERNEL).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous frame restart.
- pix_in  in  N  input pixel, two's complement.
- pix_valid  in  1  pix_in valid this cycle.
- data2conv  out  KERNEL*KERNEL*N  packed window.
- en_out  out  1  data2conv valid (1-cycle strobe per window).
- frame_done  out  1  1-cycle pulse after last pixel of frame.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-low. While rst=0:
  - col, row, en_out, frame_done, data2conv all cleared to 0.
  - Line-buffer contents need not be cleared; they are never used before being rewritten, because of row gating.
- Acceptance: a pixel is accepted on any clk edge with pix_valid=1. No backpressure: the downstream calc stage is fully pipelined and always accepts.
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0, incrementing row.
  - row runs 0..IMG_H-1.
  - Accepting pixel (IMG_H-1, IMG_W-1) returns both counters to 0 and asserts frame_done on the next cycle.
- Window content: after accepting the pixel at (r,c), the window holds pixels (r-KERNEL+1 .. r, c-KERNEL+1 .. c).
- Packing:
  - Slot i = a*KERNEL + b, with a = window row (0 = oldest/top) and b = window column (0 = leftmost).
  - Slot i occupies data2conv[i*N +: N].
- Output timing:
  - en_out=1 in the cycle after accepting (r,c) if r >= KERNEL-1 and c >= KERNEL-1; otherwise en_out=0.
  - Latency is 1 cycle from the accepting edge to registered data2conv/en_out.
  - data2conv holds its value when en_out=0. Its content is don't-care except when en_out=1.
- Stall: pix_valid=0 means no shift, no counter change, and en_out=0 next cycle. Arbitrary gaps are allowed.
- Row wrap: columns 0..KERNEL-2 of each row never produce en_out. The horizontal shift register is not flushed at wrap; gating alone masks stale columns.
- flush=1:
  - Counters go to 0 and en_out=0 next cycle; frame_done is not pulsed.
  - flush wins over a simultaneous pix_valid; that pixel is dropped.
- Back-to-back frames: the first pixel of frame k+1 may arrive the cycle after the last pixel of frame k.
- Window count: exactly (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1) en_out strobes per frame.
- KERNEL=1: no line buffers; every accepted pixel produces en_out, with data2conv = pix_in delayed 1 cycle.
- Line buffers: each is IMG_W-KERNEL deep (KERNEL row registers complete the row length). Read and write happen on the same accepting edge.

Decomposition:
- Shared header/package: clog2-based width constants COL_W = clog2(IMG_W) and ROW_W = clog2(IMG_H), and the slot-index packing helper, so the calc stage and the bench share the same ordering.
- One sub-module: conv_line_buffer, a single-row delay line parameterised by DEPTH and N with shift-on-enable. It is instantiated KERNEL-1 times via generate and omitted when KERNEL=1.

Test Plan:
- First window: KERNEL=3, N=4, IMG_W=5, IMG_H=4, pixel (r,c) = (5r+c) mod 16, continuous valid. The first en_out comes 1 cycle after pixel 12 is accepted, with slots 0..8 = 0,1,2,5,6,7,10,11,12.
- Full frame: same setup. Exactly 6 en_out strobes. The last window has slots 7,8,9,12,13,14,1,2,3 (17..19 mod 16), and frame_done pulses once, coincident with the last en_out.
- Gapped input: same frame with pix_valid toggling 1,0,0,1 randomly. Window values and count are identical to the continuous case, and en_out never asserts in a gap cycle.
- Reset mid-frame: drop rst low after pixel 8, then restart the frame. No en_out until new-frame pixel 12, and its window matches the first-window values exactly.
- flush plus back-to-back frames: flush with pix_valid=1 at pixel 7 drops that pixel and restarts counters. Two consecutive full frames then give 12 en_out strobes and 2 frame_done pulses.
- KERNEL=1, N=4: stream 3,-2,7 gives data2conv = 3,-2,7 (bits 0011,1110,0111) on 3 consecutive en_out cycles.
